btb_1bit: RTL
=============

Name: btb_1bit

Overview:
- Branch target buffer with a 1-bit direction predictor per entry.
- Sits at the other end of the branch decision interface from the ID-stage branch control unit.
- Produces the IF-stage lookup pair hp = {hit, pred} and the predicted target.
- Carries that pair through an IF/ID register as hpd.
- Accepts write-target (wrt) and write-prediction (wrp) commands from ID-stage branch control and updates the table.

Parameters:
- ENTRIES, 16, number of direct-mapped entries; must be a power of two, minimum 2.
- ADDR_W, 32, PC and target width.
- IDX_W, $clog2(ENTRIES), index width. Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_if  in  ADDR_W  PC of the instruction being fetched.
- hp  out  2  IF-stage lookup: [1] hit, [0] predicted taken. Combinational from pc_if and the table.
- pred_target  out  ADDR_W  stored target of the hit entry; 0 when no hit.
- stall  in  1  holds the IF/ID register and blocks table writes.
- flush  in  1  clears the IF/ID register contents.
- hpd  out  2  registered hp of the instruction now in ID.
- pc_id  out  ADDR_W  registered pc_if of the instruction now in ID.
- wrt  in  1  write tag, target and valid for the ID-stage branch.
- wrp  in  1  write the prediction bit for the ID-stage branch.
- taken  in  1  resolved branch outcome in ID (equal compare result).
- branch_target  in  ADDR_W  computed target of the ID-stage branch.

Behaviour:
- Storage per entry: valid, tag (ADDR_W-IDX_W-2 bits), target (ADDR_W bits), pred (1 bit).
- Reset (rst_n low, asynchronous):
  - All valid and pred bits cleared.
  - hpd = 2'b00, pc_id = 0.
  - Outputs immediately reflect this: hp = 2'b00, pred_target = 0 during and after reset.
  - Tag and target arrays are don't-care after reset.
- Lookup, 0-cycle latency:
  - hit = valid[idx(pc_if)] && (tag == tag(pc_if)).
  - hp = {hit, hit & pred}.
  - pred_target = hit ? target : 0.
- IF/ID register, priority flush > stall > load:
  - flush = 1: hpd <= 2'b00, pc_id <= 0.
  - stall = 1 and flush = 0: hold hpd and pc_id.
  - Otherwise: hpd <= hp, pc_id <= pc_if.
- Table writes, addressed by idx(pc_id) and tag(pc_id); performed only when stall = 0:
  - wrt = 1: valid <= 1, tag <= tag(pc_id), target <= branch_target.
  - wrp = 1: pred <= taken.
  - wrt = 1, wrp = 0: pred unchanged.
  - wrt = 0, wrp = 0: no change.
  - flush does not block writes. A flush in the same cycle as a write is the normal mispredict case, and the write must complete.
- Same-cycle read and write to the same index: lookup returns pre-write contents; no bypass. The new value is visible on the next cycle.
- Aliasing: a wrt to an occupied index overwrites it (replacement, no eviction notice). wrp only, with no prior wrt, updates pred of whatever entry is at that index.
- Reset asserted mid-operation: any pending write is discarded; the table is invalidated.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds outputs lookup_hits (32 bits) and mispredicts (32 bits), both reset to 0 and saturating at all-ones.
  - lookup_hits increments on each cycle with stall = 0, flush = 0 and hp[1] = 1.
  - mispredicts increments on each cycle with stall = 0 and hpd[1] = 1 and hpd[0] != taken.
- Undefined: both ports and both counters absent; all other behaviour identical.

Decomposition:
- Shared package btb_pkg:
  - HP_HIT_BIT = 1, HP_PRED_BIT = 0.
  - Typedef btb_entry_t {valid, tag, target, pred}.
  - Function btb_idx(pc).
  - Function btb_tag(pc).
- One natural sub-module, btb_ifid_reg: the hpd/pc_id pipeline register with flush/stall priority.
- Table and lookup logic stay in btb_1bit.

Test Plan:
- Reset, then pc_if = 0x40 -> hp = 00, pred_target = 0. Next edge -> hpd = 00, pc_id = 0x40.
- Allocate: pc_id = 0x40, wrt = wrp = 1, taken = 1, branch_target = 0x80. Then pc_if = 0x40 -> hp = 11, pred_target = 0x80. pc_if = 0x440 (same index, other tag) -> hp = 00.
- Mispredict update: entry 0x40 is predicted taken; apply wrp = 1, wrt = 0, taken = 0 -> hp = 10, target still 0x80.
- Same-cycle write and read: allocate 0x50 while pc_if = 0x50 -> hp = 00 that cycle, 11 the next.
- stall = 1 with wrt = wrp = 1 -> table unchanged, hpd/pc_id held. flush and stall together -> hpd = 00, pc_id = 0.
- BTB_STATS_EN: 3 hitting lookups, then one hpd = 11 with taken = 0 -> lookup_hits = 3, mispredicts = 1. Assert rst_n low mid-sequence -> both counters 0 and hp = 00 immediately.

Source files
------------

// File: rtl/btb_pkg.sv
// ============================================================================
// Module      : btb_pkg
// Description : Shared constants, entry type and PC field helpers for the
//               1-bit branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_pkg;

    localparam int HP_HIT_BIT  = 1;
    localparam int HP_PRED_BIT = 0;

    // Widest PC the helpers and entry view can carry; callers truncate.
    localparam int BTB_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
        logic                 pred;
    } btb_entry_t;

    function automatic logic [BTB_MAX_W-1:0] btb_idx(input logic [BTB_MAX_W-1:0] pc,
                                                     input int unsigned          idx_w);
        logic [BTB_MAX_W-1:0] mask;
        mask = (BTB_MAX_W'(1) << idx_w) - BTB_MAX_W'(1);
        return (pc >> 2) & mask;
    endfunction

    function automatic logic [BTB_MAX_W-1:0] btb_tag(input logic [BTB_MAX_W-1:0] pc,
                                                     input int unsigned          idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_ifid_reg.sv
// ============================================================================
// Module      : btb_ifid_reg
// Description : IF/ID pipeline register for the BTB lookup pair and PC,
//               with flush taking priority over stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_ifid_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        hp,
    input  logic [ADDR_W-1:0] pc_if,
    output logic [1:0]        hpd,
    output logic [ADDR_W-1:0] pc_id
);

    logic [1:0]        r_hpd;
    logic [ADDR_W-1:0] r_pc_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpd   <= 2'b00;
            r_pc_id <= '0;
        end else if (flush) begin
            r_hpd   <= 2'b00;
            r_pc_id <= '0;
        end else if (!stall) begin
            r_hpd   <= hp;
            r_pc_id <= pc_if;
        end
    end

    assign hpd   = r_hpd;
    assign pc_id = r_pc_id;

endmodule

`default_nettype wire

// File: rtl/btb_1bit.sv
// ============================================================================
// Module      : btb_1bit
// Description : Direct-mapped branch target buffer with a 1-bit direction
//               predictor per entry. Define BTB_STATS_EN to add hit and
//               mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_1bit
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_if,
    output logic [1:0]        hp,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        hpd,
    output logic [ADDR_W-1:0] pc_id,
    input  logic              wrt,
    input  logic              wrp,
    input  logic              taken,
    input  logic [ADDR_W-1:0] branch_target
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       lookup_hits,
    output logic [31:0]       mispredicts
`endif
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_pred;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];

    logic [IDX_W-1:0]   w_rd_idx;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [TAG_W-1:0]   w_wr_tag;
    btb_entry_t         w_rd_entry;
    logic               w_hit;
    logic [1:0]         w_hp;
    logic               w_unused_entry;

    assign w_rd_idx = IDX_W'(btb_idx(BTB_MAX_W'(pc_if), IDX_W));
    assign w_rd_tag = TAG_W'(btb_tag(BTB_MAX_W'(pc_if), IDX_W));
    assign w_wr_idx = IDX_W'(btb_idx(BTB_MAX_W'(pc_id), IDX_W));
    assign w_wr_tag = TAG_W'(btb_tag(BTB_MAX_W'(pc_id), IDX_W));

    // Lookup reads the pre-write table contents; no write-to-read bypass.
    always_comb begin
        w_rd_entry        = '0;
        w_rd_entry.valid  = r_valid[w_rd_idx];
        w_rd_entry.tag    = BTB_MAX_W'(r_tag[w_rd_idx]);
        w_rd_entry.target = BTB_MAX_W'(r_target[w_rd_idx]);
        w_rd_entry.pred   = r_pred[w_rd_idx];
    end

    assign w_hit = w_rd_entry.valid && (w_rd_entry.tag == BTB_MAX_W'(w_rd_tag));

    always_comb begin
        w_hp              = 2'b00;
        w_hp[HP_HIT_BIT]  = w_hit;
        w_hp[HP_PRED_BIT] = w_hit & w_rd_entry.pred;
    end

    assign hp             = w_hp;
    assign pred_target    = w_hit ? ADDR_W'(w_rd_entry.target) : '0;
    assign w_unused_entry = ^w_rd_entry;

    // Only valid/pred need reset; tag/target are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_pred  <= '0;
        end else if (!stall) begin
            if (wrt) r_valid[w_wr_idx] <= 1'b1;
            if (wrp) r_pred[w_wr_idx]  <= taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !stall && wrt) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= branch_target;
        end
    end

    btb_ifid_reg #(
        .ADDR_W (ADDR_W)
    ) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .hp    (w_hp),
        .pc_if (pc_if),
        .hpd   (hpd),
        .pc_id (pc_id)
    );

`ifdef BTB_STATS_EN
    logic [31:0] r_lookup_hits;
    logic [31:0] r_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lookup_hits <= '0;
            r_mispredicts <= '0;
        end else if (!stall) begin
            if (!flush && w_hp[HP_HIT_BIT] && (r_lookup_hits != '1))
                r_lookup_hits <= r_lookup_hits + 32'd1;
            if (hpd[HP_HIT_BIT] && (hpd[HP_PRED_BIT] != taken) && (r_mispredicts != '1))
                r_mispredicts <= r_mispredicts + 32'd1;
        end
    end

    assign lookup_hits = r_lookup_hits;
    assign mispredicts = r_mispredicts;
`endif

endmodule

`default_nettype wire
